// File: rtl/piccolo_pkg.sv
// piccolo_pkg: shared Piccolo constants, F-function and key-schedule helpers
package piccolo_pkg;

    typedef enum logic {S_IDLE, S_RUN} dec_state_t;

    localparam int ROUNDS = 25;
    localparam logic [31:0] CON = 32'h0f1e2d3c;
    localparam logic [3:0] SBOX [16] = '{4'he, 4'h4, 4'hb, 4'h2, 4'h3, 4'h8, 4'h0, 4'h9,
                                         4'h1, 4'ha, 4'h7, 4'hf, 4'h6, 4'hc, 4'h5, 4'hd};
    localparam logic [1:0] MCOEF [4][4] = '{'{2'd2, 2'd3, 2'd1, 2'd1},
                                            '{2'd1, 2'd2, 2'd3, 2'd1},
                                            '{2'd1, 2'd1, 2'd2, 2'd3},
                                            '{2'd3, 2'd1, 2'd1, 2'd2}};
    // output byte p takes input byte RP_MAP[p]
    localparam int RP_MAP [8] = '{2, 7, 4, 1, 6, 3, 0, 5};

    function automatic logic [3:0] xtime(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [1:0] c);
        return c == 2'd1 ? a : c == 2'd2 ? xtime(a) : xtime(a) ^ a;
    endfunction

    function automatic logic [15:0] f_func(input logic [15:0] x);
        logic [3:0] s [4];
        logic [3:0] m [4];
        logic [15:0] y;
        for (int i = 0; i < 4; i++) s[i] = SBOX[x[15-4*i -: 4]];
        for (int r = 0; r < 4; r++) begin
            m[r] = 4'h0;
            for (int c = 0; c < 4; c++) m[r] = m[r] ^ gmul(s[c], MCOEF[r][c]);
        end
        for (int i = 0; i < 4; i++) y[15-4*i -: 4] = SBOX[m[i]];
        return y;
    endfunction

    // encryption round-key pair (rk2j, rk2j+1); k0 sits in k[79:64]
    function automatic logic [31:0] rk_pair(input logic [4:0] j, input logic [79:0] k);
        logic [4:0] c;
        logic [31:0] con;
        logic [2:0] m;
        c = j + 5'd1;
        con = {c, 5'd0, c, 2'b00, c, 5'd0, c} ^ CON;
        m = 3'(j % 5'd5);
        return con ^ ((m == 3'd0 || m == 3'd2) ? k[47:16] :
                      m == 3'd3 ? {k[15:0], k[15:0]} : k[79:48]);
    endfunction

    // {wk0, wk1}
    function automatic logic [31:0] wk_lo(input logic [79:0] k);
        return {k[79:72], k[55:48], k[63:56], k[71:64]};
    endfunction

    // {wk2, wk3}
    function automatic logic [31:0] wk_hi(input logic [79:0] k);
        return {k[15:8], k[23:16], k[31:24], k[7:0]};
    endfunction

endpackage

// File: rtl/piccolo_round_f.sv
// piccolo_round_f: one Piccolo round (two F-functions plus optional byte permutation)
module piccolo_round_f
    import piccolo_pkg::*;
(
    input  logic [63:0] x,
    input  logic [15:0] rk0,
    input  logic [15:0] rk1,
    input  logic        last,
    output logic [63:0] y
);
    logic [63:0] t;
    // Feistel update of both branches; the final round skips the permutation
    always_comb begin
        t = {x[63:48], x[47:32] ^ f_func(x[63:48]) ^ rk0,
             x[31:16], x[15:0] ^ f_func(x[31:16]) ^ rk1};
        y = t;
        if (!last)
            for (int p = 0; p < 8; p++) y[63-8*p -: 8] = t[63-8*RP_MAP[p] -: 8];
    end
endmodule

// File: rtl/piccolo80_dec.sv
// piccolo80_dec: iterative Piccolo-80 decryption, one round per clock
module piccolo80_dec
    import piccolo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [0:79] key,
    input  logic [0:63] ciphertext,
    output logic        busy,
    output logic        done,
    output logic [0:63] plaintext
);
    dec_state_t st, st_nx;
    logic [4:0]  rnd;
    logic [79:0] key_r, k_in;
    logic [63:0] x, x_nx, c_in;
    logic [31:0] pair, wl, wh;
    logic [15:0] rk0, rk1;
    logic        last, go;

    assign k_in = key;
    assign c_in = ciphertext;
    assign last = rnd == 5'(ROUNDS - 1);
    assign go   = st == S_IDLE && start;
    assign busy = st == S_RUN;
    assign wl   = wk_lo(key_r);
    assign wh   = wk_hi(k_in);
    // decryption walks the schedule backwards and swaps the pair on odd rounds
    assign pair = rk_pair(5'(ROUNDS - 1) - rnd, key_r);
    assign rk0  = rnd[0] ? pair[15:0] : pair[31:16];
    assign rk1  = rnd[0] ? pair[31:16] : pair[15:0];

    piccolo_round_f u_round (
        .x    (x),
        .rk0  (rk0),
        .rk1  (rk1),
        .last (last),
        .y    (x_nx)
    );

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) st <= S_IDLE;
        else st <= st_nx;

    // next state: accept in idle, return to idle after the last round
    always_comb begin
        st_nx = st;
        st_nx = st == S_IDLE ? (start ? S_RUN : S_IDLE) : (last ? S_IDLE : S_RUN);
    end

    // datapath: latch inputs on accept, iterate rounds, whiten and publish result
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rnd       <= 5'd0;
            key_r     <= 80'h0;
            x         <= 64'h0;
            done      <= 1'b0;
            plaintext <= 64'h0;
        end else begin
            done <= st == S_RUN && last;
            if (go) begin
                key_r <= k_in;
                x     <= c_in ^ {wh[31:16], 16'h0, wh[15:0], 16'h0};
                rnd   <= 5'd0;
            end else if (st == S_RUN) begin
                x   <= x_nx;
                rnd <= rnd + 5'd1;
                if (last) plaintext <= x_nx ^ {wl[31:16], 16'h0, wl[15:0], 16'h0};
            end
        end
endmodule
